// File: rtl/bus_dma_master_if.sv
// Bus master port of the two-master/two-slave shared bus.
//   m_req     master -> arbiter  bus request
//   m_grant   arbiter -> master  bus grant
//   m_wr      master -> slaves   1 = write, 0 = read
//   m_address master -> slaves   word address
//   m_dout    master -> slaves   write data
//   m_din     slaves -> master   read data, valid the cycle after the read address
interface bus_dma_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();
  logic              m_req;
  logic              m_grant;
  logic              m_wr;
  logic [ADDR_W-1:0] m_address;
  logic [DATA_W-1:0] m_dout;
  logic [DATA_W-1:0] m_din;

  modport master (
    output m_req, m_wr, m_address, m_dout,
    input  m_grant, m_din
  );

  modport slave (
    input  m_req, m_wr, m_address, m_dout,
    output m_grant, m_din
  );
endinterface

// File: rtl/bus_dma_master.sv
// Block-copy DMA engine acting as a master on the shared bus.
// A command (source, destination, word count) is accepted in IDLE; the engine
// then requests the bus and copies words one at a time with a read phase
// (RD), a capture phase (CAP) and a write phase (WR), 3 cycles per word.
// Completion is signalled by a one-cycle done pulse.
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   start     command strobe, only looked at in IDLE
//   src_addr  first source word address
//   dst_addr  first destination word address
//   size      number of words to copy (0 = complete immediately)
//   busy      high from the cycle after an accepted start through DONE
//   done      one-cycle completion pulse
//   bus       master side of the bus (request/grant, address, data)
module bus_dma_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  size,
  output logic              busy,
  output logic              done,
  bus_dma_master_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RD,
    S_CAP,
    S_WR,
    S_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] src_reg, src_next;
  logic [ADDR_W-1:0] dst_reg, dst_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [CNT_W-1:0]  index_reg, index_next;
  logic [DATA_W-1:0] buf_reg, buf_next;

  logic [CNT_W-1:0]  index_inc;
  logic [ADDR_W-1:0] index_addr;

  assign index_inc  = index_reg + CNT_W'(1);
  // Address sums are kept at ADDR_W bits so they wrap naturally.
  assign index_addr = ADDR_W'(index_reg);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      src_reg   <= '0;
      dst_reg   <= '0;
      count_reg <= '0;
      index_reg <= '0;
      buf_reg   <= '0;
    end else begin
      state_reg <= state_next;
      src_reg   <= src_next;
      dst_reg   <= dst_next;
      count_reg <= count_next;
      index_reg <= index_next;
      buf_reg   <= buf_next;
    end
  end

  // Next state and outputs. Every bus phase is qualified by m_grant: losing
  // the grant in RD/CAP/WR drops back to REQ with index untouched, so the
  // current word restarts from its read phase and nothing is half-written.
  always_comb begin
    state_next    = state_reg;
    src_next      = src_reg;
    dst_next      = dst_reg;
    count_next    = count_reg;
    index_next    = index_reg;
    buf_next      = buf_reg;
    busy          = 1'b0;
    done          = 1'b0;
    bus.m_req     = 1'b0;
    bus.m_wr      = 1'b0;
    bus.m_address = '0;
    bus.m_dout    = '0;

    unique case (state_reg)
      S_IDLE: begin
        if (start) begin
          if (size != '0) begin
            src_next   = src_addr;
            dst_next   = dst_addr;
            count_next = size;
            index_next = '0;
            state_next = S_REQ;
          end else begin
            state_next = S_DONE;
          end
        end
      end

      S_REQ: begin
        busy      = 1'b1;
        bus.m_req = 1'b1;
        if (bus.m_grant) state_next = S_RD;
      end

      S_RD: begin
        busy      = 1'b1;
        bus.m_req = 1'b1;
        if (bus.m_grant) begin
          bus.m_address = src_reg + index_addr;
          state_next    = S_CAP;
        end else begin
          state_next = S_REQ;
        end
      end

      S_CAP: begin
        busy      = 1'b1;
        bus.m_req = 1'b1;
        if (bus.m_grant) begin
          buf_next   = bus.m_din;
          state_next = S_WR;
        end else begin
          state_next = S_REQ;
        end
      end

      S_WR: begin
        busy      = 1'b1;
        bus.m_req = 1'b1;
        if (bus.m_grant) begin
          bus.m_wr      = 1'b1;
          bus.m_address = dst_reg + index_addr;
          bus.m_dout    = buf_reg;
          index_next    = index_inc;
          state_next    = (index_inc == count_reg) ? S_DONE : S_RD;
        end else begin
          state_next = S_REQ;
        end
      end

      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_dma_master.sv
module tb_bus_dma_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  src_addr, dst_addr, size_in;
  logic        busy, done;

  // Bench-side arbiter and memory (one 256-word space covering both slaves).
  logic        grant_reg, drop, drop_dir, rand_drop, req_prev;
  logic        wr_pend, rd_pend;
  logic [7:0]  wr_pa, rd_pa;
  logic [31:0] wr_pd, din;
  logic [31:0] mem [256];

  // Reference model: expected write stream and expected memory image.
  logic [31:0] model_mem [256];
  logic [7:0]  exp_wa [$];
  logic [31:0] exp_wd [$];
  logic [7:0]  cur_src;
  int          writes_done, done_cnt;
  int          rel_req, rel_grant, rel_done, last_rd1;
  int          n_checks = 0, n_pass = 0, cyc = 0;

  bus_dma_master_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  assign bus.m_grant = grant_reg & ~drop;
  assign bus.m_din   = din;

  bus_dma_master #(.ADDR_W(8), .DATA_W(32), .CNT_W(8)) dut (
    .clk      (clk),
    .reset_n  (rst_n),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .size     (size_in),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One bus cycle: apply the effects of the edge that just passed (slave
  // write/read, arbiter grant = request delayed one cycle), then compare the
  // DUT outputs for the current cycle against the model.
  task automatic tick();
    logic [7:0]  ea;
    logic [31:0] ed;
    logic        quiet_ok;
    @(negedge clk);
    cyc++;
    if (wr_pend) mem[wr_pa] = wr_pd;
    if (rd_pend) din = mem[rd_pa];
    grant_reg = req_prev;
    drop = drop_dir | (rand_drop && ($urandom_range(0, 5) == 0));
    #1;
    if (rst_n) begin
      quiet_ok = (bus.m_req && bus.m_grant) ? (bus.m_wr || bus.m_dout == '0)
                 : (!bus.m_wr && bus.m_address == '0 && bus.m_dout == '0);
      check(quiet_ok, "bus_quiet", 64'({bus.m_wr, bus.m_address, bus.m_dout}), 64'(0));
      check(!(bus.m_req || done) || busy, "busy_level", 64'(busy), 64'(1));
      if (bus.m_wr) begin
        if (exp_wa.size() == 0) begin
          check(1'b0, "unexpected_write", 64'({bus.m_address, bus.m_dout}), 64'(0));
        end else begin
          ea = exp_wa.pop_front();
          ed = exp_wd.pop_front();
          check(bus.m_address == ea && bus.m_dout == ed, "write",
                64'({bus.m_address, bus.m_dout}), 64'({ea, ed}));
          model_mem[ea] = ed;
          writes_done++;
        end
      end
      // A read phase with a non-zero address must target src + words done.
      if (bus.m_req && bus.m_grant && !bus.m_wr && bus.m_address != '0) begin
        ea = cur_src + 8'(writes_done);
        check(bus.m_address == ea, "read_addr", 64'(bus.m_address), 64'(ea));
      end
      if (done) begin
        done_cnt++;
        check(exp_wa.size() == 0, "done_early", 64'(exp_wa.size()), 64'(0));
      end
    end
    req_prev = bus.m_req;
    wr_pend  = bus.m_wr && bus.m_grant;
    wr_pa    = bus.m_address;
    wr_pd    = bus.m_dout;
    rd_pend  = bus.m_req && bus.m_grant && !bus.m_wr;
    rd_pa    = bus.m_address;
  endtask

  // Issue one copy command and follow it to completion (or to a reset).
  // drop_a/drop_b: cycles (relative to the start cycle) with grant forced low.
  // alt_k: cycle in which a second start with other fields is presented.
  // rst_k: cycle after which reset_n is pulled low.
  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n,
                          input int drop_a, input int drop_b, input int alt_k,
                          input int rst_k, input bit rdrop);
    logic [31:0] scratch [256];
    int budget, bad;
    for (int i = 0; i < 256; i++) scratch[i] = model_mem[i];
    exp_wa.delete();
    exp_wd.delete();
    for (int i = 0; i < int'(n); i++) begin
      exp_wa.push_back(d + 8'(i));
      exp_wd.push_back(scratch[s + 8'(i)]);
      scratch[d + 8'(i)] = scratch[s + 8'(i)];
    end
    cur_src = s; writes_done = 0; done_cnt = 0;
    rel_req = -1; rel_grant = -1; rel_done = -1; last_rd1 = -1;
    rand_drop = rdrop;
    src_addr = s; dst_addr = d; size_in = n; start = 1'b1;
    budget = 60 + 40 * int'(n);
    for (int k = 1; k <= budget; k++) begin
      drop_dir = (k == drop_a) || (k == drop_b);
      tick();
      start = (k + 1 == alt_k);
      if (start) begin
        src_addr = 8'h00; dst_addr = 8'h50; size_in = 8'd7;
      end
      if (bus.m_req && rel_req < 0) rel_req = k;
      if (bus.m_req && bus.m_grant && rel_grant < 0) rel_grant = k;
      if (bus.m_grant && !bus.m_wr && bus.m_address == s + 8'd1) last_rd1 = k;
      if (done) rel_done = k;
      if (k == rst_k) begin
        rst_n = 1'b0;
        #1;
        check(bus.m_req == 1'b0 && bus.m_wr == 1'b0, "rst_req_wr", 64'({bus.m_req, bus.m_wr}), 64'(0));
        check(bus.m_address == '0, "rst_address", 64'(bus.m_address), 64'(0));
        check(busy == 1'b0 && done == 1'b0, "rst_busy_done", 64'({busy, done}), 64'(0));
        exp_wa.delete();
        exp_wd.delete();
        drop_dir = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
          tick();
          check(!bus.m_req && !busy && !done, "post_reset_idle", 64'({bus.m_req, busy, done}), 64'(0));
        end
        break;
      end
      if (rel_done >= 0 && k == rel_done + 1) begin
        check(busy == 1'b0, "busy_fall", 64'(busy), 64'(0));
        break;
      end
    end
    drop_dir = 1'b0;
    rand_drop = 1'b0;
    start = 1'b0;
    if (rst_k < 0) begin
      check(rel_done >= 0, "done_timeout", 64'(rel_done), 64'(1));
      check(done_cnt == 1, "done_count", 64'(done_cnt), 64'(1));
      check(exp_wa.size() == 0, "writes_missing", 64'(exp_wa.size()), 64'(0));
    end else begin
      check(done_cnt == 0, "done_after_reset", 64'(done_cnt), 64'(0));
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== model_mem[i]) bad++;
    check(bad == 0, "mem_final", 64'(bad), 64'(0));
    $display("copy src=%02h dst=%02h size=%0d req_at=%0d done_at=%0d writes=%0d",
             s, d, n, rel_req, rel_done, writes_done);
  endtask

  initial begin
    logic [31:0] v;
    rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; size_in = '0;
    grant_reg = 1'b0; drop = 1'b0; drop_dir = 1'b0; rand_drop = 1'b0;
    req_prev = 1'b0; wr_pend = 1'b0; rd_pend = 1'b0; wr_pa = '0; rd_pa = '0;
    wr_pd = '0; din = '0; cur_src = '0; writes_done = 0; done_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      model_mem[i] = mem[i];
    end
    tick();
    tick();
    check(busy == 1'b0 && done == 1'b0, "reset_busy_done", 64'({busy, done}), 64'(0));
    check(!bus.m_req && !bus.m_wr, "reset_req_wr", 64'({bus.m_req, bus.m_wr}), 64'(0));
    check(bus.m_address == '0 && bus.m_dout == '0, "reset_addr_dout", 64'({bus.m_address, bus.m_dout}), 64'(0));
    rst_n = 1'b1;
    tick();

    // Basic 4-word copy with literal timing and data.
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    for (int i = 0; i < 4; i++) model_mem[i] = mem[i];
    run_copy(8'h00, 8'h40, 8'd4, -1, -1, -1, -1, 1'b0);
    check(rel_req == 1, "req_rise", 64'(rel_req), 64'(1));
    check(rel_done == 15, "done_cycle", 64'(rel_done), 64'(15));
    check(rel_done == rel_grant + 13, "done_after_first_rd", 64'(rel_done - rel_grant - 1), 64'(12));
    check(mem[8'h40] == 32'h11 && mem[8'h41] == 32'h22, "lit_data_lo",
          64'({mem[8'h40], mem[8'h41]}), 64'({32'h11, 32'h22}));
    check(mem[8'h42] == 32'h33 && mem[8'h43] == 32'h44, "lit_data_hi",
          64'({mem[8'h42], mem[8'h43]}), 64'({32'h33, 32'h44}));

    // Zero-length command: straight to done, no bus activity.
    run_copy(8'h10, 8'h60, 8'd0, -1, -1, -1, -1, 1'b0);
    check(rel_req == -1, "size0_no_req", 64'(rel_req), 64'(-1));
    check(rel_done == 1, "size0_done", 64'(rel_done), 64'(1));

    // Address wrap with overlapping regions: every destination gets old mem[FE].
    v = mem[8'hFE];
    run_copy(8'hFE, 8'hFF, 8'd3, -1, -1, -1, -1, 1'b0);
    check(mem[8'hFF] == v && mem[8'h00] == v && mem[8'h01] == v, "wrap_data",
          64'({mem[8'h00], mem[8'h01]}), 64'({v, v}));
    check(rel_done == 12, "wrap_done", 64'(rel_done), 64'(12));

    // Grant lost for 2 cycles during the WR of word 1.
    run_copy(8'h20, 8'h90, 8'd3, 8, 9, -1, -1, 1'b0);
    check(last_rd1 == 11, "reread_word1", 64'(last_rd1), 64'(11));
    check(rel_done == 17, "grant_loss_done", 64'(rel_done), 64'(17));

    // Second start while busy is ignored.
    run_copy(8'h30, 8'hA0, 8'd4, -1, -1, 5, -1, 1'b0);
    check(rel_done == 15, "restart_ignored_done", 64'(rel_done), 64'(15));

    // Reset during CAP of word 2.
    run_copy(8'h10, 8'h80, 8'd3, -1, -1, -1, 10, 1'b0);

    // Randomized commands with random grant loss.
    for (int t = 0; t < 25; t++) begin
      run_copy(8'($urandom), 8'($urandom), 8'($urandom_range(1, 24)), -1, -1, -1, -1, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
